// File: rtl/bcd_contador_ndigitos.sv
// N-digit cascaded BCD up/down counter with load, clear, wrap/saturate terminal
// handling, a registered terminal-count pulse and per-digit seven-segment decode.
module bcd_contador_ndigitos #(
  parameter int N_DIG   = 3,
  parameter bit WRAP    = 1'b1,
  parameter bit SEG_LOW = 1'b1
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 enb,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [4*N_DIG-1:0]   ld_val,
  input  logic                 dn,
  output logic [4*N_DIG-1:0]   bcd,
  output logic [7*N_DIG-1:0]   sgm,
  output logic                 cnt_max,
  output logic                 tc
);

  localparam int W = 4 * N_DIG;
  localparam logic [W-1:0] NINES = {N_DIG{4'h9}};

  logic [W-1:0]     stepped;
  logic [W-1:0]     ld_clean;
  logic [W-1:0]     bcd_nxt;
  logic [N_DIG-1:0] inc_en;
  logic [N_DIG-1:0] dec_en;
  logic             run9;
  logic             run0;
  logic             stp_term;
  logic             tc_nxt;

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Parallel carry/borrow lookahead: digit k moves when every lower digit sits at 9 (up) or 0 (down)
  always_comb begin
    run9   = 1'b1;
    run0   = 1'b1;
    inc_en = '0;
    dec_en = '0;
    for (int k = 0; k < N_DIG; k++) begin
      inc_en[k] = run9;
      dec_en[k] = run0;
      run9      = run9 & (bcd[4*k +: 4] == 4'd9);
      run0      = run0 & (bcd[4*k +: 4] == 4'd0);
    end
  end

  for (genvar k = 0; k < N_DIG; k++) begin : g_dig
    logic [3:0] d;
    logic [3:0] up_d;
    logic [3:0] dn_d;
    logic [3:0] raw_ld;
    logic [6:0] seg_raw;

    assign d       = bcd[4*k +: 4];
    assign up_d    = (d == 4'd9) ? 4'd0 : d + 4'd1;
    assign dn_d    = (d == 4'd0) ? 4'd9 : d - 4'd1;
    assign raw_ld  = ld_val[4*k +: 4];
    assign seg_raw = seg_dec(d);

    assign stepped[4*k +: 4]  = dn ? (dec_en[k] ? dn_d : d) : (inc_en[k] ? up_d : d);
    assign ld_clean[4*k +: 4] = (raw_ld > 4'd9) ? 4'd0 : raw_ld;
    assign sgm[7*k +: 7]      = SEG_LOW ? ~seg_raw : seg_raw;
  end

  assign cnt_max  = dn ? (bcd == '0) : (bcd == NINES);
  assign stp_term = dn ? (stepped == '0) : (stepped == NINES);

  // Wrap mode flags leaving the terminal value; saturate mode flags arriving at it
  always_comb begin
    bcd_nxt = bcd;
    tc_nxt  = 1'b0;
    if (clr) begin
      bcd_nxt = '0;
    end else if (ld) begin
      bcd_nxt = ld_clean;
    end else if (enb) begin
      if (cnt_max) begin
        if (WRAP) begin
          bcd_nxt = stepped;
          tc_nxt  = 1'b1;
        end
      end else begin
        bcd_nxt = stepped;
        tc_nxt  = !WRAP && stp_term;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      bcd <= '0;
      tc  <= 1'b0;
    end else begin
      bcd <= bcd_nxt;
      tc  <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_contador_ndigitos.sv
// Scoreboard bench: four counter builds share stimulus; a decimal-integer model
// predicts each one, expectations are queued per step and popped after the edge.
module tb_bcd_contador_ndigitos;

  logic        ck = 1'b0;
  logic        rst_n, enb, clr, ld, dn;
  logic [31:0] ld_val;

  logic [11:0] bcd3, bcds;
  logic [20:0] sgm3, sgms;
  logic [3:0]  bcd1;
  logic [6:0]  sgm1;
  logic [31:0] bcd8;
  logic [55:0] sgm8;
  logic        cm3, cms, cm1, cm8, tc3, tcs, tc1, tc8;

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint v3, vs, v1, v8;
    logic   t3, ts, t1, t8;
  } exp_t;

  exp_t   sb[$];
  longint v3, vs, v1, v8;

  always #5 ck = ~ck;

  bcd_contador_ndigitos u3 (
    .ck(ck), .rst_n(rst_n), .enb(enb), .clr(clr), .ld(ld), .ld_val(ld_val[11:0]), .dn(dn),
    .bcd(bcd3), .sgm(sgm3), .cnt_max(cm3), .tc(tc3));

  bcd_contador_ndigitos #(.N_DIG(3), .WRAP(1'b0), .SEG_LOW(1'b0)) us (
    .ck(ck), .rst_n(rst_n), .enb(enb), .clr(clr), .ld(ld), .ld_val(ld_val[11:0]), .dn(dn),
    .bcd(bcds), .sgm(sgms), .cnt_max(cms), .tc(tcs));

  bcd_contador_ndigitos #(.N_DIG(1), .WRAP(1'b1), .SEG_LOW(1'b1)) u1 (
    .ck(ck), .rst_n(rst_n), .enb(enb), .clr(clr), .ld(ld), .ld_val(ld_val[3:0]), .dn(dn),
    .bcd(bcd1), .sgm(sgm1), .cnt_max(cm1), .tc(tc1));

  bcd_contador_ndigitos #(.N_DIG(8), .WRAP(1'b1), .SEG_LOW(1'b0)) u8 (
    .ck(ck), .rst_n(rst_n), .enb(enb), .clr(clr), .ld(ld), .ld_val(ld_val), .dn(dn),
    .bcd(bcd8), .sgm(sgm8), .cnt_max(cm8), .tc(tc8));

  function automatic longint pw10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic longint from_ld(input logic [31:0] lv, input int n);
    longint r = 0;
    for (int k = n - 1; k >= 0; k--) begin
      logic [3:0] d;
      d = lv[4*k +: 4];
      r = r * 10 + ((d > 4'd9) ? 0 : longint'(d));
    end
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input longint v, input int n);
    logic [31:0] r = '0;
    longint t = v;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [55:0] segs(input logic [31:0] b, input int n, input bit low);
    logic [55:0] r = '0;
    for (int k = 0; k < n; k++) r[7*k +: 7] = low ? ~seg7(b[4*k +: 4]) : seg7(b[4*k +: 4]);
    return r;
  endfunction

  function automatic logic cmax(input longint v, input int n);
    return dn ? (v == 0) : (v == pw10(n) - 1);
  endfunction

  // Reference step on decimal integers; reads the inputs currently being driven
  function automatic void mstep(input int n, input bit wrap, input longint v,
                                output longint nv, output logic t);
    longint mx = pw10(n) - 1;
    nv = v;
    t  = 1'b0;
    if (clr) nv = 0;
    else if (ld) nv = from_ld(ld_val, n);
    else if (enb) begin
      if (!dn) begin
        if (v == mx) begin
          if (wrap) begin nv = 0; t = 1'b1; end
        end else begin
          nv = v + 1; t = !wrap && (nv == mx);
        end
      end else begin
        if (v == 0) begin
          if (wrap) begin nv = mx; t = 1'b1; end
        end else begin
          nv = v - 1; t = !wrap && (nv == 0);
        end
      end
    end
  endfunction

  function automatic logic [63:0] exp_state(input exp_t e);
    logic [31:0] x8, x1, xs, x3;
    x8 = to_bcd(e.v8, 8); x1 = to_bcd(e.v1, 1); xs = to_bcd(e.vs, 3); x3 = to_bcd(e.v3, 3);
    return {x8, x1[3:0], xs[11:0], x3[11:0], e.t8, e.t1, e.ts, e.t3};
  endfunction

  function automatic logic [108:0] exp_disp(input exp_t e);
    logic [55:0] s8, s1, ss, s3;
    s8 = segs(to_bcd(e.v8, 8), 8, 1'b0);
    s1 = segs(to_bcd(e.v1, 1), 1, 1'b1);
    ss = segs(to_bcd(e.vs, 3), 3, 1'b0);
    s3 = segs(to_bcd(e.v3, 3), 3, 1'b1);
    return {s8, s1[6:0], ss[20:0], s3[20:0], cmax(e.v8, 8), cmax(e.v1, 1), cmax(e.vs, 3), cmax(e.v3, 3)};
  endfunction

  task automatic step(input logic c, input logic l, input logic en, input logic d,
                      input logic [31:0] v);
    exp_t   x;
    longint nv;
    logic   t;
    clr = c; ld = l; enb = en; dn = d; ld_val = v;
    mstep(3, 1'b1, v3, nv, t); v3 = nv; x.v3 = nv; x.t3 = t;
    mstep(3, 1'b0, vs, nv, t); vs = nv; x.vs = nv; x.ts = t;
    mstep(1, 1'b1, v1, nv, t); v1 = nv; x.v1 = nv; x.t1 = t;
    mstep(8, 1'b1, v8, nv, t); v8 = nv; x.v8 = nv; x.t8 = t;
    sb.push_back(x);
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    clr = 0; ld = 0; enb = 0; dn = 0; ld_val = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    v3 = 0; vs = 0; v1 = 0; v8 = 0;
    #2;
    checks++;
    if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== 64'd0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3});
    end
    checks++;
    if (sgm3 !== {3{7'h40}} || sgms !== {3{7'h3F}}) begin
      errors++;
      $display("FAIL reset_sgm got %h/%h want %h/%h", sgm3, sgms, {3{7'h40}}, {3{7'h3F}});
    end
    checks++;
    if ({cm8, cm1, cms, cm3} !== 4'b0000) begin
      errors++; $display("FAIL reset_cnt_max_up got %b want 0000", {cm8, cm1, cms, cm3});
    end
    dn = 1'b1;
    #1;
    checks++;
    if ({cm8, cm1, cms, cm3} !== 4'b1111) begin
      errors++; $display("FAIL reset_cnt_max_dn got %b want 1111", {cm8, cm1, cms, cm3});
    end
    dn = 1'b0;
    @(negedge ck);
    rst_n = 1'b1;
    @(posedge ck);
    #1;
  endtask

  task automatic test_up_full();
    exp_t e;
    int   tc_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      e = sb.pop_front();
      checks++;
      if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e)) begin
        errors++;
        $display("FAIL up_full_state cycle %0d got %h want %h", i,
                 {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, exp_state(e));
      end
      if (tc3) tc_seen++;
      if (i % 97 == 0) begin
        checks++;
        if ({sgm8, sgm1, sgms, sgm3, cm8, cm1, cms, cm3} !== exp_disp(e)) begin
          errors++;
          $display("FAIL up_full_disp cycle %0d got %h want %h", i,
                   {sgm8, sgm1, sgms, sgm3, cm8, cm1, cms, cm3}, exp_disp(e));
        end
      end
    end
    checks++;
    if (tc_seen != 1 || bcd3 !== 12'h000 || tc3 !== 1'b1) begin
      errors++;
      $display("FAIL up_full_wrap tc_count=%0d bcd=%h tc=%b want 1 000 1", tc_seen, bcd3, tc3);
    end
  endtask

  task automatic test_load_invalid();
    exp_t e;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00F9);
    e = sb.pop_front();
    checks++;
    if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e) || bcd3 !== 12'h009) begin
      errors++;
      $display("FAIL load_invalid got %h want %h", {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, exp_state(e));
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00F9);
    e = sb.pop_front();
    checks++;
    if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e) || bcd3 !== 12'h010) begin
      errors++;
      $display("FAIL load_then_step got %h want %h", {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, exp_state(e));
    end
    checks++;
    if ({sgm8, sgm1, sgms, sgm3, cm8, cm1, cms, cm3} !== exp_disp(e)) begin
      errors++;
      $display("FAIL load_disp got %h want %h", {sgm8, sgm1, sgms, sgm3, cm8, cm1, cms, cm3}, exp_disp(e));
    end
  endtask

  task automatic test_saturate_down();
    exp_t        e;
    logic [11:0] seq [5] = '{12'h001, 12'h000, 12'h000, 12'h000, 12'h000};
    int          pulses = 0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0002);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      e = sb.pop_front();
      checks++;
      if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e) || bcds !== seq[i]
          || cms !== (i >= 1)) begin
        errors++;
        $display("FAIL sat_down step %0d bcd=%h cnt_max=%b state=%h want bcd=%h state=%h", i,
                 bcds, cms, {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, seq[i], exp_state(e));
      end
      if (tcs) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL sat_tc_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0555);
    void'(sb.pop_front());
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0555);
    e = sb.pop_front();
    checks++;
    if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e) || bcd3 !== 12'h000 || tc3 !== 1'b0) begin
      errors++;
      $display("FAIL priority_clr got %h want %h", {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, exp_state(e));
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0123);
    e = sb.pop_front();
    checks++;
    if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e) || bcd3 !== 12'h123) begin
      errors++;
      $display("FAIL priority_ld got %h want %h", {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, exp_state(e));
    end
  endtask

  task automatic test_direction();
    exp_t        e;
    logic [11:0] pat = 12'b0011_0110_0111;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0500);
    void'(sb.pop_front());
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, pat[i], 32'h0);
      e = sb.pop_front();
      checks++;
      if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e)) begin
        errors++;
        $display("FAIL direction step %0d got %h want %h", i,
                 {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, exp_state(e));
      end
    end
  endtask

  task automatic test_boundary_sweep();
    exp_t        e;
    logic [31:0] starts [2] = '{32'h9999_9998, 32'h0000_0001};
    for (int s = 0; s < 2; s++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, starts[s]);
      void'(sb.pop_front());
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 1'b0, 1'b1, (s == 0) ? (i >= 3) : (i < 3), 32'h0);
        e = sb.pop_front();
        checks++;
        if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e)) begin
          errors++;
          $display("FAIL sweep %0d step %0d got %h want %h", s, i,
                   {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, exp_state(e));
        end
        checks++;
        if ({sgm8, sgm1, sgms, sgm3, cm8, cm1, cms, cm3} !== exp_disp(e)) begin
          errors++;
          $display("FAIL sweep_disp %0d step %0d got %h want %h", s, i,
                   {sgm8, sgm1, sgms, sgm3, cm8, cm1, cms, cm3}, exp_disp(e));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0437);
    void'(sb.pop_front());
    enb = 1'b1; ld = 1'b1; ld_val = 32'h0000_0999;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bcd3 !== 12'h000 || tc3 !== 1'b0 || sgm3 !== {3{7'h40}} || cm3 !== dn || bcd8 !== 32'h0) begin
      errors++;
      $display("FAIL async_reset bcd=%h tc=%b sgm=%h cnt_max=%b want 000 0 %h %b",
               bcd3, tc3, sgm3, cm3, {3{7'h40}}, dn);
    end
    v3 = 0; vs = 0; v1 = 0; v8 = 0;
    sb.delete();
    #1 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    e = sb.pop_front();
    checks++;
    if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e) || bcd3 !== 12'h001) begin
      errors++;
      $display("FAIL resume_after_reset got %h want %h", {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, exp_state(e));
    end
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 5) == 0) ? ~dn : dn, $urandom());
      e = sb.pop_front();
      checks++;
      if ({bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3} !== exp_state(e)) begin
        errors++;
        $display("FAIL random_state cycle %0d got %h want %h", i,
                 {bcd8, bcd1, bcds, bcd3, tc8, tc1, tcs, tc3}, exp_state(e));
      end
      checks++;
      if ({sgm8, sgm1, sgms, sgm3, cm8, cm1, cms, cm3} !== exp_disp(e)) begin
        errors++;
        $display("FAIL random_disp cycle %0d got %h want %h", i,
                 {sgm8, sgm1, sgms, sgm3, cm8, cm1, cms, cm3}, exp_disp(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_full();
    test_load_invalid();
    test_saturate_down();
    test_priority();
    test_direction();
    test_boundary_sweep();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_contador_ndigitos.md
BCD_CONTADOR_NDIGITOS -- requirements
Module: bcd_contador_ndigitos

Interface
REQ-001 Parameter N_DIG, default 3: number of cascaded BCD digits; legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 = count wraps at terminal value; 0 = count saturates at terminal value.
REQ-003 Parameter SEG_LOW, default 1: 1 = segment outputs active-low; 0 = active-high.
REQ-004 Port ck  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port enb  input  1  count enable; one step per cycle while high.
REQ-007 Port clr  input  1  synchronous clear to all-zero.
REQ-008 Port ld  input  1  synchronous load of ld_val.
REQ-009 Port ld_val  input  4*N_DIG  preset value; digit k at bits [4k+3:4k], digit 0 least significant.
REQ-010 Port dn  input  1  direction: 0 = up, 1 = down.
REQ-011 Port bcd  output  4*N_DIG  current count, registered, same packing as ld_val.
REQ-012 Port sgm  output  7*N_DIG  seven-segment code per digit; digit k at bits [7k+6:7k], bit order g..a (bit 0 = a).
REQ-013 Port cnt_max  output  1  high when count equals the terminal value for the current dn (all 9s up, all 0s down).
REQ-014 Port tc  output  1  registered one-cycle pulse, high in the cycle after a counting step that left the terminal value.

Function
REQ-015 Per-edge priority SHALL be clr > ld > enb; with none active, count holds.
REQ-016 clr SHALL set every digit to 0 regardless of ld, enb, dn.
REQ-017 ld SHALL load ld_val; any digit field > 9 SHALL be loaded as 0, other digits unaffected.
REQ-018 Up step: digit 0 increments; digit k (k>0) increments only when all digits below k equal 9; a digit at 9 that increments becomes 0.
REQ-019 Down step: digit 0 decrements; digit k (k>0) decrements only when all digits below k equal 0; a digit at 0 that decrements becomes 9.
REQ-020 The full N_DIG-digit update SHALL complete in one cycle; no ripple delay between digits.
REQ-021 cnt_max SHALL be combinational on bcd and dn, independent of enb; it reflects dn changes in the same cycle.
REQ-022 WRAP=1, enb high, cnt_max high: count SHALL wrap (up: all 9s -> all 0s; down: all 0s -> all 9s), and tc SHALL be high in the following cycle.
REQ-023 WRAP=0, enb high, cnt_max high: count SHALL hold, and tc SHALL pulse exactly once per arrival at the terminal value (not while held).
REQ-024 tc SHALL be low after any clr or ld cycle and in all cycles with no counting step.
REQ-025 dn changing while enb is high SHALL take effect on the next edge with no lost or extra step.
REQ-026 sgm SHALL be combinational from bcd: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, active-high, bits g..a), inverted when SEG_LOW=1.
REQ-027 Digit codes 10..15 are unreachable; if present, sgm for that digit SHALL show segment g only.
REQ-028 bcd and tc SHALL be outputs of flip-flops; no combinational path from enb/ld/clr/ld_val to bcd.

Reset
REQ-029 rst_n low SHALL immediately, without waiting for ck, force all digits to 0 and tc to 0.
REQ-030 During reset, sgm SHALL show 0 on every digit and cnt_max SHALL equal dn.
REQ-031 Reset deassertion SHALL be synchronized to the ck domain by the integrator; the block SHALL count from the first rising edge with rst_n high.
REQ-032 Reset asserted mid-count or mid-load SHALL discard the operation; no partial-digit state SHALL survive.

Verification
REQ-033 N_DIG=3, WRAP=1, dn=0, enb high for 1000 cycles from reset -> bcd steps 000..999, wraps to 000, tc high exactly once, in the cycle after 999->000.
REQ-034 ld_val=0x0F9 (digit1=F) with ld=1 -> bcd=0x009; next enb step up -> 0x010.
REQ-035 WRAP=0, ld 0x002, dn=1, enb high for 5 cycles -> 001, 000, 000, 000, 000; tc pulses once; cnt_max high from 000.
REQ-036 clr, ld, enb all high, count 0x555 -> bcd=0x000 next edge; tc=0.
REQ-037 rst_n pulsed low between edges at count 0x437 -> bcd=0x000 before next edge; sgm=3F3F3F inverted (SEG_LOW=1); count resumes 001 on first edge after release.
REQ-038 N_DIG=1 and N_DIG=8 builds, up/down sweep across a 9->0 and 0->9 boundary -> matches reference model every cycle.
